// File: rtl/mdu_sched_if.sv
// ============================================================================
// Module   : mdu_sched_if
// Brief    : E/D-stage signal bundle between the pipeline and the MDU scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mdu_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, d_md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_md_use,
    output busy, stall, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mdu_sched.sv
// ============================================================================
// Module   : mdu_sched
// Brief    : MULT/DIV busy scheduler holding HI/LO and raising the D-stage stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_sched_if.slave  bus
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_op;
  logic [31:0]          r_rs;
  logic [31:0]          r_rt;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_rt_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_div_by_zero;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{r_rs[31]}}, r_rs} * {{32{r_rt[31]}}, r_rt};
  assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

  // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (q wraps to 0x80000000).
  assign w_signed      = ~r_op[0];
  assign w_rs_mag      = (w_signed & r_rs[31]) ? (32'd0 - r_rs) : r_rs;
  assign w_rt_mag      = (w_signed & r_rt[31]) ? (32'd0 - r_rt) : r_rt;
  assign w_div_by_zero = (r_rt == 32'd0);
  assign w_rt_div      = w_div_by_zero ? 32'd1 : w_rt_mag;
  assign w_q_mag       = w_rs_mag / w_rt_div;
  assign w_r_mag       = w_rs_mag % w_rt_div;
  assign w_q           = (w_signed & (r_rs[31] ^ r_rt[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r           = (w_signed & r_rs[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              r_op    <= bus.op[1:0];
              r_rs    <= bus.rs_val;
              r_rt    <= bus.rt_val;
              r_cnt   <= bus.op[1] ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else if (bus.op[1:0] == 2'b00) begin
              r_hi <= bus.rs_val;
            end else if (bus.op[1:0] == 2'b01) begin
              r_lo <= bus.rs_val;
            end
          end
        end
        S_RUN: begin
          // New starts are ignored here; the stall keeps a correct pipeline from issuing them.
          if (r_cnt == c_cnt_w'(1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_op[1]) begin
              {r_hi, r_lo} <= r_op[0] ? w_prod_u : w_prod_s;
            end else if (!w_div_by_zero) begin
              r_lo <= w_q;
              r_hi <= w_r;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.stall = bus.d_md_use & (r_busy | bus.start);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sched.sv
// ============================================================================
// Module   : tb_mdu_sched
// Brief    : Self-checking bench for mdu_sched: vector table, corner sequences, random ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_sched;

  logic clk;
  logic reset;
  mdu_sched_if ifc();

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        dmu;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference semantics straight from the MIPS definitions, using 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin sq = sa * sb; {m_hi, m_lo} = sq; end
      3'd1: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = pu; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmu, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int cyc;
    ifc.start    = 1'b1;
    ifc.op       = op;
    ifc.rs_val   = a;
    ifc.rt_val   = b;
    ifc.d_md_use = dmu;
    #1;
    check({tag, ".stall_start"}, 64'(ifc.stall), 64'(dmu));
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.op    = 3'b110;
    #1;
    cyc = 0;
    while (ifc.busy && cyc < 40) begin
      cyc++;
      if (ifc.stall !== dmu) begin
        check({tag, ".stall_busy"}, 64'(ifc.stall), 64'(dmu));
      end
      @(posedge clk); #2;
    end
    check({tag, ".busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".stall_after"}, 64'(ifc.stall), 64'd0);
    check({tag, ".hi"}, 64'(ifc.hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(ifc.lo), 64'(exp_lo));
  endtask

  initial begin
    int cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        rdmu;

    tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1] = '{3'd1, 32'hFFFFFFFD, 32'd5,        1'b0, 5,  32'h00000004, 32'hFFFFFFF1};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd3, 32'd7,        32'd2,        1'b0, 10, 32'h00000001, 32'h00000003};
    tbl[4] = '{3'd4, 32'h11,       32'd0,        1'b1, 0,  32'h00000011, 32'h00000003};
    tbl[5] = '{3'd5, 32'h22,       32'd0,        1'b0, 0,  32'h00000011, 32'h00000022};
    tbl[6] = '{3'd3, 32'd5,        32'd0,        1'b1, 10, 32'h00000011, 32'h00000022};
    tbl[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
    tbl[8] = '{3'd6, 32'h1234,     32'h5678,     1'b1, 0,  32'h00000000, 32'h80000000};

    reset        = 1'b0;
    ifc.start    = 1'b1;
    ifc.op       = 3'd0;
    ifc.rs_val   = 32'd9;
    ifc.rt_val   = 32'd9;
    ifc.d_md_use = 1'b1;
    #3;
    check("reset.busy", 64'(ifc.busy), 64'd0);
    check("reset.hi", 64'(ifc.hi), 64'd0);
    check("reset.lo", 64'(ifc.lo), 64'd0);
    check("reset.stall_start", 64'(ifc.stall), 64'd1);
    ifc.start = 1'b0;
    #1;
    check("reset.stall_idle", 64'(ifc.stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].dmu, tbl[i].cyc,
             tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
    end

    // MTLO arriving while a MULT runs must be dropped.
    ifc.start = 1'b1; ifc.op = 3'd0; ifc.rs_val = 32'd3; ifc.rt_val = 32'd7; ifc.d_md_use = 1'b0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    cyc = 0;
    while (ifc.busy && cyc < 40) begin
      if (cyc == 1) begin
        ifc.start = 1'b1; ifc.op = 3'd5; ifc.rs_val = 32'hABCD;
      end else begin
        ifc.start = 1'b0;
      end
      cyc++;
      @(posedge clk); #1;
    end
    ifc.start = 1'b0;
    check("ignore.busy_cycles", 64'(cyc), 64'd5);
    check("ignore.lo", 64'(ifc.lo), 64'd21);
    check("ignore.hi", 64'(ifc.hi), 64'd0);

    // Asynchronous reset in the middle of a DIV discards the result.
    ifc.start = 1'b1; ifc.op = 3'd2; ifc.rs_val = 32'd100; ifc.rt_val = 32'd7; ifc.d_md_use = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort.busy_before", 64'(ifc.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort.busy", 64'(ifc.busy), 64'd0);
    check("abort.hi", 64'(ifc.hi), 64'd0);
    check("abort.lo", 64'(ifc.lo), 64'd0);
    check("abort.stall", 64'(ifc.stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("abort.busy_later", 64'(ifc.busy), 64'd0);
    check("abort.hi_later", 64'(ifc.hi), 64'd0);
    check("abort.lo_later", 64'(ifc.lo), 64'd0);
    run_op(3'd0, 32'd6, 32'd7, 1'b1, 5, 32'd0, 32'd42, "abort.mult");

    // Randomized ops against the reference model.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      rdmu = 1'($urandom_range(0, 1));
      model(rop, ra, rb);
      run_op(rop, ra, rb, rdmu, (rop < 3'd2) ? 5 : ((rop < 3'd4) ? 10 : 0),
             m_hi, m_lo, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide unit scheduler for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage, runs a multi-cycle busy counter and holds HI/LO. Generates the D-stage stall when an MDU-using instruction must wait for the unit. Sits beside the ALU in E; its `stall` output is ORed into the pipeline pause logic.

## Interface
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (>=1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (>=1)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low (0 = reset); clears all state immediately
- start  input  1  E-stage instruction is an MDU operation this cycle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO data)
- rt_val  input  32  forwarded rt operand (divisor / multiplier)
- d_md_use  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  output  1  unit is executing a multi-cycle operation
- stall  output  1  D-stage hold request (combinational)
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE (busy=0), RUN (busy=1). Down-counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}: latch rs_val, rt_val, op; cnt <= MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, start=1, op=MTHI: hi <= rs_val at that edge; stay IDLE. MTLO: lo <= rs_val likewise.
- IDLE, op 110/111 or start=0: no state change.
- RUN: cnt decrements each edge. On the edge where cnt==1: write result, cnt <= 0, go IDLE.
- RUN, start=1 (any op): ignored; latched operands, HI/LO and cnt unaffected. Does not occur in correct pipelines because of `stall`.
- MULT: {hi,lo} <= signed 32x32 -> 64-bit product. MULTU: unsigned product.
- DIV: lo <= signed quotient truncated toward zero, hi <= remainder with the dividend's sign. DIVU: unsigned quotient/remainder.
- DIV/DIVU with divisor 0: unit still RUN for DIV_CYCLES; hi/lo left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall = d_md_use & (busy | start). Comb; no dependence on op.
- Reset (reset=0), at any time including mid-RUN: busy=0, cnt=0, hi=0, lo=0, latched operands=0, state IDLE; any in-flight result discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0, stall = d_md_use & start (comb).
- start sampled at edge E0: busy=1 from just after E0 through the cycle before edge E0+N (N = MULT_CYCLES or DIV_CYCLES); busy high exactly N cycles.
- hi/lo take the new result at edge E0+N, the same edge busy falls; an MFHI/MFLO in E after that edge reads the new value.
- A new MDU op may start at edge E0+N+1 at earliest (start while busy is ignored).
- MTHI/MTLO: single cycle, visible on hi/lo after the sampling edge; busy never asserts.
- stall asserted in the start cycle and all N busy cycles when d_md_use=1; deasserts in the cycle after the completion edge.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; after the 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy stays 0); DIVU rs=5, rt=0 -> busy 10 cycles, then hi=0x11, lo=0x22.
- d_md_use=1 held while MULT issued -> stall=1 in start cycle plus 5 busy cycles, 0 afterwards; d_md_use=0 -> stall=0 throughout.
- MULT in RUN, start=1 with MTLO rs=0xABCD at cycle 2 -> ignored; final lo = product, not 0xABCD.
- DIV started, reset pulled low at cycle 4 -> busy, hi, lo 0 immediately; after release no result written, unit accepts a new MULT.
